// File: rtl/dcm_ctrl_pkg.sv
// Shared definitions for the DCM lock sequencer: state encoding, default timing
// constants and the saturating retry-count helper.
package dcm_ctrl_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_RST       = 3'd1;
   localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
   localparam logic [2:0] ST_STABLE    = 3'd3;
   localparam logic [2:0] ST_RUN       = 3'd4;
   localparam logic [2:0] ST_FAIL      = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE      = ST_IDLE,
      S_RST       = ST_RST,
      S_WAIT_LOCK = ST_WAIT_LOCK,
      S_STABLE    = ST_STABLE,
      S_RUN       = ST_RUN,
      S_FAIL      = ST_FAIL
   } state_e;

   localparam int DEF_RST_CYCLES   = 8;
   localparam int DEF_LOCK_TIMEOUT = 65535;
   localparam int DEF_LOCK_STABLE  = 256;
   localparam int DEF_MAX_RETRY    = 15;
   localparam int DEF_CNT_WIDTH    = 16;

   function automatic logic [3:0] retry_inc(input logic [3:0] cnt, input logic [3:0] max_cnt);
      logic [3:0] r;
      if (cnt >= max_cnt) begin
         r = max_cnt;
      end else begin
         r = cnt + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchroniser for asynchronous status bits, one chain per bit.
module bit_sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Synchroniser chain; cleared on reset so no stale status survives it.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/dcm_lock_seq.sv
// DCM_SP bring-up sequencer: pulses DCM RST, waits for and qualifies LOCKED,
// releases the deserializer reset, and retries on timeout or lock loss.
module dcm_lock_seq
   import dcm_ctrl_pkg::*;
#(
   parameter int RST_CYCLES   = DEF_RST_CYCLES,
   parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
   parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
   parameter int MAX_RETRY    = DEF_MAX_RETRY,
   parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       locked_in,
   input  logic       clkin_stop,
   output logic       dcm_reset,
   output logic       deser_reset,
   output logic       clk_ready,
   output logic       lock_fail,
   output logic [3:0] retry_cnt
);

   localparam logic [CNT_WIDTH-1:0] RST_LAST = CNT_WIDTH'(RST_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(LOCK_TIMEOUT - 1);
   // The WAIT_LOCK cycle that saw lock counts as the first stable cycle.
   localparam logic [CNT_WIDTH-1:0] STB_LAST = CNT_WIDTH'(LOCK_STABLE - 2);
   localparam logic [3:0]           RETRY_MAX = 4'(MAX_RETRY);

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] timer_q, timer_d;
   logic [3:0]           retry_q, retry_d;
   logic                 dcm_reset_q, dcm_reset_d;
   logic                 deser_reset_q, deser_reset_d;
   logic                 clk_ready_q, clk_ready_d;
   logic                 lock_fail_q, lock_fail_d;

   logic [1:0]           sync_s;
   logic                 lock_ok_s;
   logic [3:0]           retry_inc_s;

   bit_sync_2ff #(.WIDTH(2)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     ({clkin_stop, locked_in}),
      .q     (sync_s)
   );

   assign lock_ok_s = sync_s[0] & ~sync_s[1];

   // Next state, timer, retry count and registered output decode.
   always_comb begin
      state_d     = state_q;
      retry_d     = retry_q;
      retry_inc_s = retry_inc(retry_q, RETRY_MAX);

      if (!enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_RST;
            S_RST: begin
               if (timer_q == RST_LAST) begin
                  state_d = S_WAIT_LOCK;
               end else begin
                  state_d = S_RST;
               end
            end
            S_WAIT_LOCK: begin
               if (lock_ok_s) begin
                  state_d = S_STABLE;
               end else if (timer_q == TO_LAST) begin
                  retry_d = retry_inc_s;
                  if (retry_inc_s == RETRY_MAX) begin
                     state_d = S_FAIL;
                  end else begin
                     state_d = S_RST;
                  end
               end else begin
                  state_d = S_WAIT_LOCK;
               end
            end
            S_STABLE: begin
               if (!lock_ok_s) begin
                  retry_d = retry_inc_s;
                  if (retry_inc_s == RETRY_MAX) begin
                     state_d = S_FAIL;
                  end else begin
                     state_d = S_RST;
                  end
               end else if (timer_q == STB_LAST) begin
                  state_d = S_RUN;
               end else begin
                  state_d = S_STABLE;
               end
            end
            S_RUN: begin
               if (!lock_ok_s) begin
                  state_d = S_RST;
               end else begin
                  state_d = S_RUN;
               end
            end
            S_FAIL:  state_d = S_FAIL;
            default: state_d = S_IDLE;
         endcase
      end

      if ((state_d == S_IDLE) || (state_d == S_RUN)) begin
         retry_d = 4'd0;
      end else begin
         retry_d = retry_d;
      end

      if (state_d != state_q) begin
         timer_d = '0;
      end else if ((state_q == S_RST) || (state_q == S_WAIT_LOCK) || (state_q == S_STABLE)) begin
         timer_d = timer_q + CNT_WIDTH'(1);
      end else begin
         timer_d = '0;
      end

      dcm_reset_d   = state_d inside {S_IDLE, S_RST, S_FAIL};
      deser_reset_d = (state_d != S_RUN);
      clk_ready_d   = (state_d == S_RUN);
      lock_fail_d   = (state_d == S_FAIL);
   end

   // State, timer, retry and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         timer_q       <= '0;
         retry_q       <= 4'd0;
         dcm_reset_q   <= 1'b1;
         deser_reset_q <= 1'b1;
         clk_ready_q   <= 1'b0;
         lock_fail_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         retry_q       <= retry_d;
         dcm_reset_q   <= dcm_reset_d;
         deser_reset_q <= deser_reset_d;
         clk_ready_q   <= clk_ready_d;
         lock_fail_q   <= lock_fail_d;
      end
   end

   assign dcm_reset   = dcm_reset_q;
   assign deser_reset = deser_reset_q;
   assign clk_ready   = clk_ready_q;
   assign lock_fail   = lock_fail_q;
   assign retry_cnt   = retry_q;

endmodule
